mon_mem_arbiter: RTL and testbench

Shares the single data-RAM port between the UART monitor (dump, trash and write commands) and the CPU load/store unit. Each requester's read or write request is captured in a one-entry pending slot. A round-robin arbiter, which the monitor can override to take priority, issues one RAM transaction at a time. A single-cycle valid/finish pulse is returned to whichever requester owns the transaction, and a timeout guards against a RAM ack that never arrives.

---
 rtl/mon_mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mon_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mon_mem_arbiter.sv
// mon_mem_arbiter
//   Shares the single data-RAM port between the UART monitor and the CPU
//   load/store unit. Each requester owns a one-entry pending slot; a
//   round-robin arbiter (monitor may force priority) issues one RAM
//   transaction at a time and returns a single-cycle valid/finish pulse to
//   the owner. A cycle counter forces completion if ram_ack never arrives.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   m_read_req/m_write_req          monitor requests (pulse or level)
//   m_adr, m_wdata                  monitor address / write data
//   m_read_valid, m_write_finish    monitor response pulses
//   c_read_req/c_write_req          CPU requests
//   c_adr, c_wdata                  CPU address / write data
//   c_read_valid, c_write_finish    CPU response pulses
//   rdata                           read data for the current owner (0 otherwise)
//   mon_prio                        monitor wins every tie
//   ram_req/ram_we/ram_adr/ram_wdata  RAM command (ram_req one cycle wide)
//   ram_ack, ram_rdata              RAM completion and read data
//   busy                            arbiter not idle
//   tmo_err, err_clr                sticky timeout flag and its clear
module mon_mem_arbiter #(
  parameter int unsigned ADR_W      = 32,
  parameter int unsigned DAT_W      = 32,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_read_req,
  input  logic             m_write_req,
  input  logic [ADR_W-1:0] m_adr,
  input  logic [DAT_W-1:0] m_wdata,
  output logic             m_read_valid,
  output logic             m_write_finish,
  input  logic             c_read_req,
  input  logic             c_write_req,
  input  logic [ADR_W-1:0] c_adr,
  input  logic [DAT_W-1:0] c_wdata,
  output logic             c_read_valid,
  output logic             c_write_finish,
  output logic [DAT_W-1:0] rdata,
  input  logic             mon_prio,
  output logic             ram_req,
  output logic             ram_we,
  output logic [ADR_W-1:0] ram_adr,
  output logic [DAT_W-1:0] ram_wdata,
  input  logic             ram_ack,
  input  logic [DAT_W-1:0] ram_rdata,
  output logic             busy,
  output logic             tmo_err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_WAIT  = 2'd2
  } state_e;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_MON  = 1'b1;
  // Timeout fires in the A_WAIT cycle whose count is TMO_CYCLES-1, so the
  // transaction spends exactly TMO_CYCLES cycles in A_WAIT.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               tmo_err_q, tmo_err_d;
  logic               ram_we_q, ram_we_d;
  logic [ADR_W-1:0]   ram_adr_q, ram_adr_d;
  logic [DAT_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic               m_pend_q, m_pend_d;
  logic               m_we_q, m_we_d;
  logic [ADR_W-1:0]   m_adr_q, m_adr_d;
  logic [DAT_W-1:0]   m_wdata_q, m_wdata_d;
  logic               c_pend_q, c_pend_d;
  logic               c_we_q, c_we_d;
  logic [ADR_W-1:0]   c_adr_q, c_adr_d;
  logic [DAT_W-1:0]   c_wdata_q, c_wdata_d;

  logic               sel_owner;
  logic               in_wait, ack_fire, tmo_fire, done, m_done, c_done;

  assign in_wait  = (state_q == A_WAIT);
  assign ack_fire = in_wait & ram_ack;
  // An ack in the final allowed cycle still counts as a normal completion.
  assign tmo_fire = in_wait & ~ram_ack & (tmo_cnt_q == TMO_LAST);
  assign done     = ack_fire | tmo_fire;
  assign m_done   = done & (owner_q == OWN_MON);
  assign c_done   = done & (owner_q == OWN_CPU);

  assign m_read_valid   = m_done & ~ram_we_q;
  assign m_write_finish = m_done &  ram_we_q;
  assign c_read_valid   = c_done & ~ram_we_q;
  assign c_write_finish = c_done &  ram_we_q;
  assign rdata          = (ack_fire & ~ram_we_q) ? ram_rdata : '0;

  assign ram_req   = (state_q == A_ISSUE);
  assign ram_we    = ram_we_q;
  assign ram_adr   = ram_adr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != A_IDLE);
  assign tmo_err   = tmo_err_q;

  always_comb begin
    if (m_pend_q && c_pend_q) begin
      sel_owner = mon_prio ? OWN_MON : ~last_owner_q;
    end else begin
      sel_owner = m_pend_q ? OWN_MON : OWN_CPU;
    end
  end

  // Pending slots: a slot being answered this cycle counts as empty, so a
  // fresh request is captured on the same edge that retires the old one.
  always_comb begin
    m_pend_d  = m_pend_q & ~m_done;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_wdata_d = m_wdata_q;
    if ((!m_pend_q || m_done) && (m_read_req || m_write_req)) begin
      m_pend_d  = 1'b1;
      m_we_d    = m_write_req;
      m_adr_d   = m_adr;
      m_wdata_d = m_wdata;
    end

    c_pend_d  = c_pend_q & ~c_done;
    c_we_d    = c_we_q;
    c_adr_d   = c_adr_q;
    c_wdata_d = c_wdata_q;
    if ((!c_pend_q || c_done) && (c_read_req || c_write_req)) begin
      c_pend_d  = 1'b1;
      c_we_d    = c_write_req;
      c_adr_d   = c_adr;
      c_wdata_d = c_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = tmo_cnt_q;
    ram_we_d     = ram_we_q;
    ram_adr_d    = ram_adr_q;
    ram_wdata_d  = ram_wdata_q;

    tmo_err_d = tmo_err_q;
    if (err_clr)  tmo_err_d = 1'b0;
    if (tmo_fire) tmo_err_d = 1'b1;

    unique case (state_q)
      A_IDLE: begin
        if (m_pend_q || c_pend_q) begin
          state_d      = A_ISSUE;
          owner_d      = sel_owner;
          last_owner_d = sel_owner;
          tmo_cnt_d    = '0;
          if (sel_owner == OWN_MON) begin
            ram_we_d    = m_we_q;
            ram_adr_d   = m_adr_q;
            ram_wdata_d = m_wdata_q;
          end else begin
            ram_we_d    = c_we_q;
            ram_adr_d   = c_adr_q;
            ram_wdata_d = c_wdata_q;
          end
        end
      end
      A_ISSUE: begin
        state_d = A_WAIT;
      end
      A_WAIT: begin
        if (done) begin
          state_d   = A_IDLE;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = A_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= A_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_CPU;
      tmo_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_adr_q    <= '0;
      ram_wdata_q  <= '0;
      m_pend_q     <= 1'b0;
      m_we_q       <= 1'b0;
      m_adr_q      <= '0;
      m_wdata_q    <= '0;
      c_pend_q     <= 1'b0;
      c_we_q       <= 1'b0;
      c_adr_q      <= '0;
      c_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_err_q    <= tmo_err_d;
      ram_we_q     <= ram_we_d;
      ram_adr_q    <= ram_adr_d;
      ram_wdata_q  <= ram_wdata_d;
      m_pend_q     <= m_pend_d;
      m_we_q       <= m_we_d;
      m_adr_q      <= m_adr_d;
      m_wdata_q    <= m_wdata_d;
      c_pend_q     <= c_pend_d;
      c_we_q       <= c_we_d;
      c_adr_q      <= c_adr_d;
      c_wdata_q    <= c_wdata_d;
    end
  end

endmodule

// File: tb/tb_mon_mem_arbiter.sv
// Directed bench for mon_mem_arbiter (TMO_CYCLES overridden to 4).
module tb_mon_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_read_req, m_write_req;
  logic [31:0] m_adr, m_wdata;
  logic        m_read_valid, m_write_finish;
  logic        c_read_req, c_write_req;
  logic [31:0] c_adr, c_wdata;
  logic        c_read_valid, c_write_finish;
  logic [31:0] rdata;
  logic        mon_prio;
  logic        ram_req, ram_we;
  logic [31:0] ram_adr, ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        busy, tmo_err, err_clr;

  int checks = 0;
  int errors = 0;

  mon_mem_arbiter #(.ADR_W(32), .DAT_W(32), .TMO_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_adr(m_adr), .m_wdata(m_wdata),
    .m_read_valid(m_read_valid), .m_write_finish(m_write_finish),
    .c_read_req(c_read_req), .c_write_req(c_write_req),
    .c_adr(c_adr), .c_wdata(c_wdata),
    .c_read_valid(c_read_valid), .c_write_finish(c_write_finish),
    .rdata(rdata), .mon_prio(mon_prio),
    .ram_req(ram_req), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .busy(busy), .tmo_err(tmo_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Ends 1 time unit after a rising edge; inputs driven here are stable
  // well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_read_req = 0; m_write_req = 0; m_adr = '0; m_wdata = '0;
    c_read_req = 0; c_write_req = 0; c_adr = '0; c_wdata = '0;
    mon_prio = 0; ram_ack = 0; ram_rdata = '0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  function automatic logic [3:0] pulses();
    return {m_read_valid, m_write_finish, c_read_valid, c_write_finish};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    checks++;
    if ({ram_req, ram_we, busy, tmo_err, pulses()} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {ram_req, ram_we, busy, tmo_err, pulses()});
    end
    checks++;
    if (ram_adr !== 32'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_ram_bus: adr %h wdata %h want 0/0", ram_adr, ram_wdata);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_mon_read();
    // cycle 0
    m_read_req = 1; m_adr = 32'h10;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy0: got %b want 0", busy); end
    step(); // cycle 1
    m_read_req = 0;
    #1;
    checks++;
    if (ram_req !== 1'b0) begin errors++; $display("FAIL mr_req_c1: got %b want 0", ram_req); end
    step(); // cycle 2: ack here must be ignored
    ram_ack = 1; ram_rdata = 32'h0BAD0BAD;
    #1;
    checks++;
    if ({ram_req, ram_we, ram_adr} !== {1'b1, 1'b0, 32'h10}) begin
      errors++; $display("FAIL mr_issue: req %b we %b adr %h want 1 0 00000010", ram_req, ram_we, ram_adr);
    end
    checks++;
    if (pulses() !== 4'b0000) begin errors++; $display("FAIL mr_ack_in_issue: pulses %b want 0000", pulses()); end
    step(); // cycle 3
    ram_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (pulses() !== 4'b1000) begin errors++; $display("FAIL mr_valid: pulses %b want 1000", pulses()); end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mr_rdata: got %h want deadbeef", rdata); end
    step(); // cycle 4
    ram_ack = 0;
    #1;
    checks++;
    if ({busy, ram_req, pulses()} !== 6'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL mr_after: busy %b req %b pulses %b rdata %h want all 0", busy, ram_req, pulses(), rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_p;
    int n;
    clear_inputs();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      m_write_req = 1; m_adr = 32'h200 + 32'(r * 8); m_wdata = 32'hA000_0000 + 32'(r);
      c_write_req = 1; c_adr = 32'h300 + 32'(r * 8); c_wdata = 32'hC000_0000 + 32'(r);
      step();
      m_write_req = 0; c_write_req = 0;
      for (int g = 0; g < 2; g++) begin
        exp_adr = (g == 0) ? 32'h200 + 32'(r * 8) : 32'h300 + 32'(r * 8);
        exp_dat = (g == 0) ? 32'hA000_0000 + 32'(r) : 32'hC000_0000 + 32'(r);
        exp_p   = (g == 0) ? 4'b0100 : 4'b0001;
        n = 0;
        while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL rr_wait r%0d g%0d: ram_req never seen", r, g); end
        checks++;
        if ({ram_we, ram_adr, ram_wdata} !== {1'b1, exp_adr, exp_dat}) begin
          errors++; $display("FAIL rr_grant r%0d g%0d: we %b adr %h wd %h want 1 %h %h", r, g, ram_we, ram_adr, ram_wdata, exp_adr, exp_dat);
        end
        step();
        ram_ack = 1;
        #1;
        checks++;
        if (pulses() !== exp_p) begin errors++; $display("FAIL rr_pulse r%0d g%0d: got %b want %b", r, g, pulses(), exp_p); end
        step();
        ram_ack = 0;
      end
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ram_req === 1'b1 || pulses() !== 4'b0000) n++;
      step();
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL rr_quiet: %0d extra active cycles want 0", n); end
  endtask

  task automatic test_mon_prio();
    logic [31:0] exp_adr;
    logic [3:0]  exp_p;
    int n;
    mon_prio = 1;
    m_write_req = 1; m_adr = 32'h400; m_wdata = 32'hB000_0000;
    c_write_req = 1; c_adr = 32'h500; c_wdata = 32'hC0DE_0000;
    step();
    m_write_req = 0; c_write_req = 0;
    for (int k = 0; k < 4; k++) begin
      exp_adr = (k < 3) ? 32'h400 + 32'(k * 4) : 32'h500;
      exp_p   = (k < 3) ? 4'b0100 : 4'b0001;
      n = 0;
      while (ram_req !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL prio_wait k%0d: ram_req never seen", k); end
      checks++;
      if (ram_adr !== exp_adr) begin errors++; $display("FAIL prio_grant k%0d: adr %h want %h", k, ram_adr, exp_adr); end
      step();
      ram_ack = 1;
      // Refill the monitor slot in the finish cycle itself.
      if (k < 2) begin
        m_write_req = 1; m_adr = 32'h400 + 32'((k + 1) * 4); m_wdata = 32'hB000_0000 + 32'(k + 1);
      end
      #1;
      checks++;
      if (pulses() !== exp_p) begin errors++; $display("FAIL prio_pulse k%0d: got %b want %b", k, pulses(), exp_p); end
      step();
      ram_ack = 0; m_write_req = 0;
    end
    mon_prio = 0;
  endtask

  task automatic test_cpu_dup_read();
    int nreq, nval;
    c_read_req = 1; c_adr = 32'h100;       // cycle 0
    step();
    c_adr = 32'h104;                        // cycle 1: slot full, ignored
    step();                                 // cycle 2
    #1;
    checks++;
    if ({ram_req, ram_we, ram_adr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL cr_issue: req %b we %b adr %h want 1 0 00000100", ram_req, ram_we, ram_adr);
    end
    step();                                 // cycle 3
    c_read_req = 0; ram_ack = 1; ram_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (pulses() !== 4'b0010 || rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL cr_valid: pulses %b rdata %h want 0010 12345678", pulses(), rdata);
    end
    step();
    ram_ack = 0;
    nreq = 0; nval = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ram_req === 1'b1) nreq++;
      if (c_read_valid === 1'b1) nval++;
      step();
    end
    checks++;
    if (nreq != 0 || nval != 0) begin
      errors++; $display("FAIL cr_single: extra ram_req %0d extra valid %0d want 0 0", nreq, nval);
    end
  endtask

  task automatic test_timeout();
    int n, early;
    m_read_req = 1; m_adr = 32'h20; ram_rdata = 32'hFFFF_FFFF;  // cycle 0
    step();
    m_read_req = 0;                                            // cycle 1
    step();                                                    // cycle 2
    #1;
    checks++;
    if (ram_req !== 1'b1) begin errors++; $display("FAIL to_issue: ram_req %b want 1", ram_req); end
    early = 0;
    for (int i = 0; i < 3; i++) begin                          // cycles 3..5
      step();
      #1;
      if (pulses() !== 4'b0000 || tmo_err !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL to_early: %0d early responses want 0", early); end
    step();                                                    // cycle 6: 4th wait cycle
    #1;
    checks++;
    if (pulses() !== 4'b1000 || rdata !== 32'h0) begin
      errors++; $display("FAIL to_pulse: pulses %b rdata %h want 1000 00000000", pulses(), rdata);
    end
    step();
    #1;
    checks++;
    if (tmo_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_err_set: tmo_err %b busy %b want 1 0", tmo_err, busy);
    end
    err_clr = 1;
    step();
    err_clr = 0;
    #1;
    checks++;
    if (tmo_err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b want 0", tmo_err); end
    // Clear held high across a second timeout: the set must win.
    err_clr = 1;
    m_read_req = 1;
    step();
    m_read_req = 0;
    n = 0;
    while (m_read_valid !== 1'b1 && n < 20) begin step(); #1; n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL to2_wait: no timeout response"); end
    step();
    #1;
    checks++;
    if (tmo_err !== 1'b1) begin errors++; $display("FAIL to_set_wins: tmo_err %b want 1", tmo_err); end
    step();
    err_clr = 0;
    #1;
    checks++;
    if (tmo_err !== 1'b0) begin errors++; $display("FAIL to_err_clr2: got %b want 0", tmo_err); end
  endtask

  task automatic test_reset_mid();
    int bad;
    m_read_req = 1; m_adr = 32'h80;   // cycle 0
    step();
    m_read_req = 0;                   // cycle 1
    step();                           // cycle 2
    step();                           // cycle 3: A_WAIT
    #1;
    checks++;
    if (busy !== 1'b1 || ram_adr !== 32'h80) begin
      errors++; $display("FAIL rm_in_wait: busy %b adr %h want 1 00000080", busy, ram_adr);
    end
    rst_n = 0; ram_ack = 1; ram_rdata = 32'h7777_7777;
    #1;
    checks++;
    if ({busy, ram_req, ram_we, tmo_err, pulses()} !== 8'h00 || ram_adr !== 32'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rm_reset: busy %b req %b pulses %b adr %h rdata %h want all 0", busy, ram_req, pulses(), ram_adr, rdata);
    end
    step();
    rst_n = 1; ram_ack = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ram_req === 1'b1 || pulses() !== 4'b0000) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rm_stale: %0d active cycles want 0", bad); end
    c_write_req = 1; c_adr = 32'h40; c_wdata = 32'h5555_AAAA;   // cycle 0
    step();
    c_write_req = 0;                                           // cycle 1
    step();                                                    // cycle 2
    #1;
    checks++;
    if ({ram_req, ram_we, ram_adr, ram_wdata} !== {1'b1, 1'b1, 32'h40, 32'h5555_AAAA}) begin
      errors++; $display("FAIL rm_next_issue: req %b we %b adr %h wd %h want 1 1 00000040 5555aaaa", ram_req, ram_we, ram_adr, ram_wdata);
    end
    step();                                                    // cycle 3
    ram_ack = 1;
    #1;
    checks++;
    if (pulses() !== 4'b0001) begin errors++; $display("FAIL rm_next_finish: pulses %b want 0001", pulses()); end
    step();
    ram_ack = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_mon_read();
    test_round_robin();
    test_mon_prio();
    test_cpu_dup_read();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
